// File: rtl/barrett_pkg.sv
// Shared constants for the Kyber-modulus Barrett reduction datapath.
// Used by the reduction core and the requester arbiter.
package barrett_pkg;

    localparam int unsigned OPW = 32;
    localparam int unsigned RESW = 16;
    localparam logic [31:0] KYBER_Q = 32'd3329;

    // m = floor(2^32 / q); the quotient estimate is low by at most one,
    // so a single conditional subtract finishes the reduction.
    localparam int unsigned BARRETT_K = 32;
    localparam logic [63:0] BARRETT_M = 64'd1290167;

endpackage

// File: rtl/barrett_reduction.sv
// Combinational reduction of a 32-bit unsigned operand modulo 3329.
// Result is fully reduced into 0..3328.
module barrett_reduction
    import barrett_pkg::*;
(
    input  logic [OPW-1:0]  i_a,
    output logic [RESW-1:0] o_r
);

    logic [63:0] w_prod;
    logic [31:0] w_qhat;
    logic [31:0] w_r;

    assign w_prod = {32'd0, i_a} * BARRETT_M;
    assign w_qhat = 32'(w_prod >> BARRETT_K);
    assign w_r    = i_a - w_qhat * KYBER_Q;

    // w_r lies in [0, 2q), so one subtract is enough
    assign o_r = (w_r >= KYBER_Q) ? 16'(w_r - KYBER_Q) : 16'(w_r);

endmodule

// File: rtl/barrett_arbiter.sv
// Round-robin arbiter feeding a two-stage Barrett reduction pipeline.
// S0 holds the granted operand, S1 holds the reduced result.
module barrett_arbiter
    import barrett_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*OPW-1:0] req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   rsp_valid,
    output logic [RESW-1:0]        rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    input  logic                   rsp_ready,
    output logic                   busy
);

    // MSB flags that some requester was found; low bits carry its index.
    function automatic logic [ID_W:0] rr_pick(
        input logic [NUM_REQ-1:0] v,
        input logic [ID_W-1:0]    p
    );
        logic [ID_W:0] r;
        int            idx;
        r = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(p) + k) % NUM_REQ;
            if (v[idx]) r = {1'b1, ID_W'(idx)};
        end
        return r;
    endfunction

    logic              r_s0_v;
    logic [OPW-1:0]    r_s0_data;
    logic [ID_W-1:0]   r_s0_id;
    logic              r_s1_v;
    logic [RESW-1:0]   r_s1_data;
    logic [ID_W-1:0]   r_s1_id;
    logic [ID_W-1:0]   r_ptr;

    logic [ID_W:0]     w_pick;
    logic              w_found;
    logic [ID_W-1:0]   w_gnt;
    logic              w_s1_load;
    logic              w_s0_load;
    logic              w_take;
    logic [OPW-1:0]    w_opnd;
    logic [ID_W-1:0]   w_ptr_nxt;
    logic [RESW-1:0]   w_red;

    assign w_pick    = rr_pick(req_valid, r_ptr);
    assign w_found   = w_pick[ID_W];
    assign w_gnt     = w_pick[ID_W-1:0];
    assign w_s1_load = !r_s1_v || rsp_ready;
    assign w_s0_load = !r_s0_v || w_s1_load;
    assign w_take    = w_s0_load && w_found;
    assign w_opnd    = req_data[int'(w_gnt)*OPW +: OPW];
    assign w_ptr_nxt = (int'(w_gnt) == NUM_REQ - 1) ? '0 : w_gnt + 1'b1;

    // Flops are already cleared during reset; gating here only keeps
    // the outward accept quiet while rst_n is low.
    always_comb begin
        req_ready = '0;
        if (w_take && rst_n) req_ready[w_gnt] = 1'b1;
    end

    barrett_reduction u_red (
        .i_a (r_s0_data),
        .o_r (w_red)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0_v    <= 1'b0;
            r_s0_data <= '0;
            r_s0_id   <= '0;
            r_ptr     <= '0;
        end else begin
            if (w_s0_load) begin
                r_s0_v <= w_take;
                if (w_take) begin
                    r_s0_data <= w_opnd;
                    r_s0_id   <= w_gnt;
                end
            end
            if (w_take) r_ptr <= w_ptr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v    <= 1'b0;
            r_s1_data <= '0;
            r_s1_id   <= '0;
        end else if (w_s1_load) begin
            r_s1_v <= r_s0_v;
            if (r_s0_v) begin
                r_s1_data <= w_red;
                r_s1_id   <= r_s0_id;
            end
        end
    end

    assign rsp_valid = r_s1_v;
    assign rsp_data  = r_s1_data;
    assign rsp_id    = r_s1_id;
    assign busy      = r_s0_v || r_s1_v;

endmodule

// File: tb/tb_barrett_arbiter.sv
// Directed + random bench for barrett_arbiter against a queue model.
// The model tracks in-flight entries, round-robin pointer and mod-q math.
module tb_barrett_arbiter;

    localparam int NR = 4;

    logic            clk;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR*32-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic            rsp_valid;
    logic [15:0]     rsp_data;
    logic [1:0]      rsp_id;
    logic            rsp_ready;
    logic            busy;

    logic [31:0] din [NR];

    assign req_data = {din[3], din[2], din[1], din[0]};

    barrett_arbiter #(.NUM_REQ(NR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] res;
        int          stamp;
    } ent_t;

    ent_t q[$];
    int   ptr;
    int   cnt;
    int   tests;
    int   fails;
    int   acc_cnt [NR];
    int   rsp_cnt [NR];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs at negedge, advance the model at posedge.
    task automatic step();
        int          w;
        logic        can;
        logic        ev;
        logic        out;
        logic [NR-1:0] exp_rdy;
        logic [31:0] opnd;
        int          oid;
        @(negedge clk);
        w = -1;
        for (int k = 0; k < NR; k++) begin
            int j;
            j = (ptr + k) % NR;
            if (w < 0 && req_valid[j]) w = j;
        end
        can = (q.size() < 2) || rsp_ready;
        exp_rdy = '0;
        if (w >= 0 && can && rst_n) exp_rdy[w] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        ev = (q.size() > 0) && (q[0].stamp < cnt);
        chk("rsp_valid", 32'(rsp_valid), 32'(ev));
        chk("busy", 32'(busy), 32'(q.size() > 0));
        if (ev) begin
            chk("rsp_data", 32'(rsp_data), q[0].res);
            chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
        end
        out  = ev && rsp_ready;
        oid  = int'(rsp_id);
        opnd = (w >= 0) ? din[w] : 32'd0;
        @(posedge clk);
        cnt++;
        if (out) begin
            rsp_cnt[oid]++;
            void'(q.pop_front());
        end
        if (exp_rdy != '0) begin
            q.push_back('{w, opnd % 32'd3329, cnt});
            ptr = (w + 1) % NR;
            acc_cnt[w]++;
        end
        #1;
    endtask

    function automatic logic [31:0] rnd_opnd();
        logic [31:0] pick [4];
        pick[0] = 32'd0;
        pick[1] = 32'd3328;
        pick[2] = 32'd3329;
        pick[3] = 32'hFFFF_FFFF;
        if ($urandom_range(0, 7) == 0) return pick[$urandom_range(0, 3)];
        return $urandom;
    endfunction

    initial begin
        logic [31:0] seq [4];
        tests = 0;
        fails = 0;
        ptr   = 0;
        cnt   = 0;
        for (int i = 0; i < NR; i++) begin
            acc_cnt[i] = 0;
            rsp_cnt[i] = 0;
            din[i]     = 32'd0;
        end
        rst_n     = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b1;
        repeat (3) step();
        chk("reset_rsp_data", 32'(rsp_data), 32'd0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        rst_n     = 1'b1;
        req_valid = '0;
        step();

        // Single requester, boundary operands back to back
        seq[0] = 32'd0;
        seq[1] = 32'd3328;
        seq[2] = 32'd3329;
        seq[3] = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            req_valid = 4'b0001;
            din[0]    = seq[i];
            step();
        end
        req_valid = '0;
        step();
        chk("ffff_res", 32'hFFFF_FFFF % 32'd3329, 32'(rsp_data));
        repeat (2) step();

        // All requesters continuously valid: rotation 0,1,2,3,...
        req_valid = '1;
        for (int i = 0; i < 12; i++) begin
            for (int r = 0; r < NR; r++) din[r] = rnd_opnd();
            step();
        end

        // Backpressure for 5 cycles with stream pending
        rsp_ready = 1'b0;
        repeat (5) step();
        rsp_ready = 1'b1;
        repeat (6) step();

        // Fill both stages, then reset mid-flight
        rsp_ready = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        q.delete();
        ptr = 0;
        rsp_ready = 1'b1;
        repeat (2) step();
        rst_n = 1'b1;
        req_valid = '1;
        repeat (4) step();
        req_valid = '0;
        repeat (3) step();

        // Random traffic
        for (int i = 0; i < NR; i++) begin
            acc_cnt[i] = 0;
            rsp_cnt[i] = 0;
        end
        for (int c = 0; c < 1600; c++) begin
            req_valid = NR'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int r = 0; r < NR; r++) din[r] = rnd_opnd();
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 20 && q.size() > 0; c++) step();
        chk("drained", 32'(q.size()), 32'd0);
        for (int i = 0; i < NR; i++) chk("id_count", rsp_cnt[i], acc_cnt[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
